// File: rtl/writeback_queue_pkg.sv
// Shared types and constants for the writeback queue and its entry storage.
package writeback_queue_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // Writes to this register are discarded when zero-dropping is enabled.
  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] value;
  } wb_entry_t;

  function automatic logic is_reg_zero(input logic [WB_ADDR_W-1:0] adr);
    return (adr == REG_ZERO);
  endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Producer handshakes, register bank write port and forwarding lookup
// bundled for the writeback queue.
interface writeback_queue_if
  import writeback_queue_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
) ();

  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDR_W-1:0]        alu_adr;
  logic [DATA_W-1:0]        alu_value;

  logic                     mem_valid;
  logic                     mem_ready;
  logic [ADDR_W-1:0]        mem_adr;
  logic [DATA_W-1:0]        mem_value;

  logic                     wenable;
  logic [ADDR_W-1:0]        wadr;
  logic [DATA_W-1:0]        wvalue;

  logic [ADDR_W-1:0]        byp_adr;
  logic                     byp_hit;
  logic [DATA_W-1:0]        byp_value;

  logic [$clog2(DEPTH):0]   count;

  // Producers, operand fetch and the bank observer sit on this side.
  modport master (
    output alu_valid, alu_adr, alu_value,
    output mem_valid, mem_adr, mem_value,
    output byp_adr,
    input  alu_ready, mem_ready,
    input  wenable, wadr, wvalue,
    input  byp_hit, byp_value,
    input  count
  );

  // The queue itself.
  modport slave (
    input  alu_valid, alu_adr, alu_value,
    input  mem_valid, mem_adr, mem_value,
    input  byp_adr,
    output alu_ready, mem_ready,
    output wenable, wadr, wvalue,
    output byp_hit, byp_value,
    output count
  );

endinterface

// File: rtl/writeback_queue_wb_fifo_mem.sv
// Entry storage for the writeback queue: two write ports at tail and tail+1,
// a head read port, and a youngest-match search over the occupied entries.
module wb_fifo_mem
  import writeback_queue_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [PTR_W-1:0]     head,
  input  logic [CNT_W-1:0]     count,
  input  logic [PTR_W-1:0]     wr_ptr,
  input  logic                 wr0_en,
  input  wb_entry_t            wr0_entry,
  input  logic                 wr1_en,
  input  wb_entry_t            wr1_entry,
  output wb_entry_t            head_entry,
  input  logic [WB_ADDR_W-1:0] byp_adr,
  output logic                 byp_hit,
  output logic [WB_DATA_W-1:0] byp_value
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] scan_idx;

  // Merge this cycle's writes into the storage image.
  always_comb begin
    mem_d = mem_q;
    if (wr0_en) begin
      mem_d[wr_ptr] = wr0_entry;
    end
    if (wr1_en) begin
      mem_d[wr_ptr + PTR_W'(1)] = wr1_entry;
    end
  end

  // Storage register; cleared on reset so no stale data is ever visible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head_entry = mem_q[head];

  // Walk from head toward tail so the last match found is the youngest.
  always_comb begin
    byp_hit   = 1'b0;
    byp_value = '0;
    scan_idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (mem_q[scan_idx].adr == byp_adr)) begin
        byp_hit   = 1'b1;
        byp_value = mem_q[scan_idx].value;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue merging ALU and memory results into a single
// register bank write port, with forwarding over still-queued results.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DATA_W    = WB_DATA_W,
  parameter int ADDR_W    = WB_ADDR_W,
  parameter int DEPTH     = 4,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  writeback_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             not_empty;
  logic [CNT_W-1:0] free;
  logic             alu_ready;
  logic             mem_ready;
  logic             alu_push;
  logic             mem_push;

  wb_entry_t        alu_entry;
  wb_entry_t        mem_entry;
  logic             wr0_en;
  logic             wr1_en;
  wb_entry_t        wr0_entry;
  wb_entry_t        wr1_entry;
  wb_entry_t        head_entry;
  logic             byp_hit;
  logic [WB_DATA_W-1:0] byp_value;

  assign alu_entry = '{adr: WB_ADDR_W'(bus.alu_adr), value: WB_DATA_W'(bus.alu_value)};
  assign mem_entry = '{adr: WB_ADDR_W'(bus.mem_adr), value: WB_DATA_W'(bus.mem_value)};

  // Readiness from free slots; the head slot popped this cycle counts as free
  // and the ALU claims the first free slot ahead of memory.
  always_comb begin
    not_empty = (count_q != '0);
    free      = CNT_DEPTH - count_q + (not_empty ? CNT_ONE : '0);
    alu_ready = (free >= CNT_ONE);
    mem_ready = bus.alu_valid ? (free >= CNT_TWO) : (free >= CNT_ONE);
    alu_push  = bus.alu_valid && alu_ready
                && !(DROP_ZERO && is_reg_zero(alu_entry.adr));
    mem_push  = bus.mem_valid && mem_ready
                && !(DROP_ZERO && is_reg_zero(mem_entry.adr));
  end

  // Steer pushes onto the two write ports so the ALU entry lands at tail.
  always_comb begin
    wr0_en    = alu_push || mem_push;
    wr0_entry = alu_push ? alu_entry : mem_entry;
    wr1_en    = alu_push && mem_push;
    wr1_entry = mem_entry;
  end

  // Pointer and occupancy update: pop whenever non-empty, push what arrived.
  always_comb begin
    head_d  = not_empty ? (head_q + PTR_W'(1)) : head_q;
    tail_d  = tail_q + PTR_W'(alu_push) + PTR_W'(mem_push);
    count_d = count_q + CNT_W'(alu_push) + CNT_W'(mem_push) - CNT_W'(not_empty);
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  wb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clock      (clock),
    .reset_n    (reset_n),
    .head       (head_q),
    .count      (count_q),
    .wr_ptr     (tail_q),
    .wr0_en     (wr0_en),
    .wr0_entry  (wr0_entry),
    .wr1_en     (wr1_en),
    .wr1_entry  (wr1_entry),
    .head_entry (head_entry),
    .byp_adr    (WB_ADDR_W'(bus.byp_adr)),
    .byp_hit    (byp_hit),
    .byp_value  (byp_value)
  );

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;
  assign bus.wenable   = not_empty;
  assign bus.wadr      = not_empty ? ADDR_W'(head_entry.adr) : '0;
  assign bus.wvalue    = not_empty ? DATA_W'(head_entry.value) : '0;
  assign bus.byp_hit   = byp_hit;
  assign bus.byp_value = DATA_W'(byp_value);
  assign bus.count     = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: a scoreboard queue mirrors the
// queued results and is compared against the bank port every cycle.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int errors = 0;

  writeback_queue_if #(.DATA_W(WB_DATA_W), .ADDR_W(WB_ADDR_W), .DEPTH(DEPTH)) wb_if ();

  writeback_queue #(
    .DATA_W    (WB_DATA_W),
    .ADDR_W    (WB_ADDR_W),
    .DEPTH     (DEPTH),
    .DROP_ZERO (1'b1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (wb_if)
  );

  always #5 clock = ~clock;

  wb_entry_t   sb[$];
  logic [31:0] bank [32];
  int          bank_writes  = 0;
  int          model_pushes = 0;
  bit          alu_acc;
  bit          mem_acc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_if.alu_valid = av;
    wb_if.alu_adr   = aa;
    wb_if.alu_value = ad;
    wb_if.mem_valid = mv;
    wb_if.mem_adr   = ma;
    wb_if.mem_value = md;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: pop on every non-empty cycle, accept per free-slot rule.
  always @(posedge clock) begin : model
    int sz;
    int free;
    bit a_rdy;
    bit m_rdy;
    alu_acc = 1'b0;
    mem_acc = 1'b0;
    if (!reset_n) begin
      sb.delete();
    end else begin
      sz    = sb.size();
      free  = DEPTH - sz + ((sz > 0) ? 1 : 0);
      a_rdy = (free >= 1);
      m_rdy = wb_if.alu_valid ? (free >= 2) : (free >= 1);
      if (sz > 0) void'(sb.pop_front());
      if (wb_if.alu_valid && a_rdy) begin
        alu_acc = 1'b1;
        if (wb_if.alu_adr != 5'd0) begin
          sb.push_back('{adr: wb_if.alu_adr, value: wb_if.alu_value});
          model_pushes++;
        end
      end
      if (wb_if.mem_valid && m_rdy) begin
        mem_acc = 1'b1;
        if (wb_if.mem_adr != 5'd0) begin
          sb.push_back('{adr: wb_if.mem_adr, value: wb_if.mem_value});
          model_pushes++;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the scoreboard.
  always @(negedge clock) begin : monitor
    int          sz;
    int          free;
    logic        hit;
    logic [31:0] val;
    sz   = sb.size();
    free = DEPTH - sz + ((sz > 0) ? 1 : 0);
    checkOutput("count", 32'(wb_if.count), 32'(sz));
    checkOutput("wenable", 32'(wb_if.wenable), 32'(sz > 0));
    checkOutput("wadr", 32'(wb_if.wadr), (sz > 0) ? 32'(sb[0].adr) : 32'd0);
    checkOutput("wvalue", wb_if.wvalue, (sz > 0) ? sb[0].value : 32'd0);
    checkOutput("alu_ready", 32'(wb_if.alu_ready), 32'(free >= 1));
    checkOutput("mem_ready", 32'(wb_if.mem_ready),
                wb_if.alu_valid ? 32'(free >= 2) : 32'(free >= 1));
    hit = 1'b0;
    val = '0;
    foreach (sb[i]) begin
      if (sb[i].adr == wb_if.byp_adr) begin
        hit = 1'b1;
        val = sb[i].value;
      end
    end
    checkOutput("byp_hit", 32'(wb_if.byp_hit), 32'(hit));
    checkOutput("byp_value", wb_if.byp_value, val);
    if (wb_if.wenable === 1'b1) begin
      bank[wb_if.wadr] = wb_if.wvalue;
      bank_writes++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int writes_before;
    int pushes_before;
    logic [4:0] adr;

    for (int i = 0; i < 32; i++) bank[i] = '0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    wb_if.byp_adr = 5'd0;

    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_wenable", 32'(wb_if.wenable), 32'd0);
    checkOutput("rst_count", 32'(wb_if.count), 32'd0);
    checkOutput("rst_wadr", 32'(wb_if.wadr), 32'd0);
    checkOutput("rst_byp_hit", 32'(wb_if.byp_hit), 32'd0);
    reset_n = 1'b1;
    tick();
    checkOutput("rst_alu_ready", 32'(wb_if.alu_ready), 32'd1);
    checkOutput("rst_mem_ready", 32'(wb_if.mem_ready), 32'd1);

    // Single ALU push, one-cycle latency to the bank
    applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("t1_wenable", 32'(wb_if.wenable), 32'd1);
    checkOutput("t1_wadr", 32'(wb_if.wadr), 32'd3);
    checkOutput("t1_wvalue", wb_if.wvalue, 32'hDEADBEEF);
    tick();
    checkOutput("t1_wenable_after", 32'(wb_if.wenable), 32'd0);
    checkOutput("t1_count_after", 32'(wb_if.count), 32'd0);

    // Simultaneous pushes to the same register: ALU first, memory wins
    wb_if.byp_adr = 5'd5;
    applyStimulus(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("t2_count", 32'(wb_if.count), 32'd2);
    checkOutput("t2_first_wvalue", wb_if.wvalue, 32'h11);
    checkOutput("t2_byp_both", wb_if.byp_value, 32'h22);
    tick();
    checkOutput("t2_second_wvalue", wb_if.wvalue, 32'h22);
    checkOutput("t2_byp_one", wb_if.byp_value, 32'h22);
    checkOutput("t2_byp_hit_one", 32'(wb_if.byp_hit), 32'd1);
    tick();
    checkOutput("t2_count_end", 32'(wb_if.count), 32'd0);
    checkOutput("t2_byp_hit_end", 32'(wb_if.byp_hit), 32'd0);
    checkOutput("t2_bank5", bank[5], 32'h22);

    // Both producers valid for 20 cycles: saturate and keep ALU flowing
    writes_before = bank_writes;
    pushes_before = model_pushes;
    wb_if.byp_adr = 5'd7;
    applyStimulus(1'b1, 5'($urandom_range(1, 31)), $urandom,
                  1'b1, 5'($urandom_range(1, 31)), $urandom);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (alu_acc) begin
        wb_if.alu_adr   = 5'($urandom_range(1, 31));
        wb_if.alu_value = $urandom;
      end
      if (mem_acc) begin
        wb_if.mem_adr   = 5'($urandom_range(1, 31));
        wb_if.mem_value = $urandom;
      end
    end
    checkOutput("t3_count_full", 32'(wb_if.count), 32'(DEPTH));
    checkOutput("t3_mem_ready_full", 32'(wb_if.mem_ready), 32'd0);
    checkOutput("t3_alu_ready_full", 32'(wb_if.alu_ready), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (DEPTH + 2) tick();
    checkOutput("t3_drained", 32'(wb_if.count), 32'd0);
    checkOutput("t3_write_count", 32'(bank_writes - writes_before),
                32'(model_pushes - pushes_before));

    // Register-0 result is accepted but never stored
    wb_if.byp_adr = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("t4_alu_ready", 32'(wb_if.alu_ready), 32'd1);
    writes_before = bank_writes;
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("t4_count", 32'(wb_if.count), 32'd0);
    checkOutput("t4_wenable", 32'(wb_if.wenable), 32'd0);
    checkOutput("t4_byp_hit", 32'(wb_if.byp_hit), 32'd0);
    tick();
    checkOutput("t4_no_write", 32'(bank_writes - writes_before), 32'd0);

    // Fill three entries, then reset asynchronously mid-cycle
    wb_if.byp_adr = 5'd9;
    applyStimulus(1'b1, 5'd7, 32'h700, 1'b1, 5'd8, 32'h800);
    tick();
    applyStimulus(1'b1, 5'd9, 32'h900, 1'b1, 5'd10, 32'hA00);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("t5_count_filled", 32'(wb_if.count), 32'd3);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("t5_wenable_rst", 32'(wb_if.wenable), 32'd0);
    checkOutput("t5_count_rst", 32'(wb_if.count), 32'd0);
    checkOutput("t5_byp_hit_rst", 32'(wb_if.byp_hit), 32'd0);
    writes_before = bank_writes;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    checkOutput("t5_no_stale_write", 32'(bank_writes - writes_before), 32'd0);

    // Nine sequential single pushes wrap the pointers twice
    for (int i = 1; i <= 9; i++) begin
      adr = 5'(i);
      applyStimulus(1'b1, adr, 32'(i) * 32'h100, 1'b0, 5'd0, 32'd0);
      tick();
      checkOutput("t6_wenable", 32'(wb_if.wenable), 32'd1);
      checkOutput("t6_wadr", 32'(wb_if.wadr), 32'(i));
      checkOutput("t6_wvalue", wb_if.wvalue, 32'(i) * 32'h100);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("t6_count_end", 32'(wb_if.count), 32'd0);
    checkOutput("t6_bank9", bank[9], 32'h900);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
